// File: rtl/spi_owner_ctrl.sv
// -----------------------------------------------------------------------------
// spi_owner_ctrl
//
// Decides who owns the shared SPI slave port: the PLC CPU or the APB2SPI
// bridge. cpu_run steers the MISO mux / NSS decoder and only ever changes
// after the host bus has been quiet (nss high, sck stable) for IDLE_CYCLES
// consecutive clk cycles, so ownership never flips inside a host frame.
// Handing the bus from CPU to bridge first asks the CPU to stop at the end
// of its scan (cpu_halt_req / cpu_halted handshake).
//
// Parameters
//   IDLE_CYCLES     quiet cycles required on the host bus before a switch
//   TIMEOUT_CYCLES  maximum cycles spent in a transition state
//                   (effective only when SPI_OWN_TIMEOUT_EN is defined)
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   spi_sck       in   host SPI clock, asynchronous to clk
//   spi_nss_in    in   host SPI chip select, active-low, asynchronous
//   run_req       in   1-cycle pulse: give bus to CPU and start it
//   halt_req      in   1-cycle pulse: stop CPU, give bus to bridge
//   cpu_halted    in   CPU has stopped at a scan boundary (level)
//   cpu_run       out  1 = CPU owns SPI, 0 = bridge owns SPI
//   cpu_halt_req  out  request to CPU to stop at end of scan (level)
//   busy          out  ownership transition in progress
//   done          out  1-cycle pulse: request completed or no-op acknowledged
//   err           out  1-cycle pulse: request aborted by timeout
//
// Build option
//   SPI_OWN_TIMEOUT_EN  when defined, transition states abort after
//                       TIMEOUT_CYCLES cycles and pulse err; otherwise they
//                       wait indefinitely and err is tied low.
// -----------------------------------------------------------------------------
module spi_owner_ctrl #(
  parameter int IDLE_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sck,
  input  logic spi_nss_in,
  input  logic run_req,
  input  logic halt_req,
  input  logic cpu_halted,
  output logic cpu_run,
  output logic cpu_halt_req,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int                IDLE_W   = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  if (IDLE_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("spi_owner_ctrl: IDLE_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    ST_HALTED,
    ST_WAIT_RUN,
    ST_RUNNING,
    ST_STOPPING,
    ST_WAIT_HALT
  } state_e;

  // ---------------------------------------------------------------------------
  // Host bus synchronisers and idle detection
  // ---------------------------------------------------------------------------
  logic              sck_q1, sck_q2, sck_q3;
  logic              nss_q1, nss_q2;
  logic              sck_edge;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              bus_idle;

  // sck_q2 is the synchronised clock; sck_q3 is only its one-cycle delay.
  assign sck_edge = sck_q2 ^ sck_q3;
  assign bus_idle = (idle_cnt_q == IDLE_MAX);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!nss_q2 || sck_edge) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Preset to the bus-released levels so reset alone causes no false edge.
      sck_q1     <= 1'b0;
      sck_q2     <= 1'b0;
      sck_q3     <= 1'b0;
      nss_q1     <= 1'b1;
      nss_q2     <= 1'b1;
      idle_cnt_q <= '0;
    end else begin
      sck_q1     <= spi_sck;
      sck_q2     <= sck_q1;
      sck_q3     <= sck_q2;
      nss_q1     <= spi_nss_in;
      nss_q2     <= nss_q1;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transition timeout
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

`ifdef SPI_OWN_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout;
  logic              err_q, err_d;

  // The counter reaches TIMEOUT_CYCLES on the same edge that aborts.
  assign timeout = (wait_cnt_q == WAIT_LAST);

  always_comb begin
    wait_cnt_d = '0;
    if (state_d == state_q &&
        state_q inside {ST_WAIT_RUN, ST_STOPPING, ST_WAIT_HALT}) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Ownership FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic cpu_run_q, cpu_run_d;
  logic halt_req_q, halt_req_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cpu_run_d  = cpu_run_q;
    halt_req_d = halt_req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SPI_OWN_TIMEOUT_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_HALTED: begin
        cpu_run_d  = 1'b0;
        halt_req_d = 1'b0;
        // halt_req has priority: a simultaneous run_req is dropped.
        if (halt_req) begin
          done_d = 1'b1;
        end else if (run_req) begin
          state_d = ST_WAIT_RUN;
          busy_d  = 1'b1;
        end
      end
      ST_WAIT_RUN: begin
        if (bus_idle) begin
          state_d   = ST_RUNNING;
          cpu_run_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
`ifdef SPI_OWN_TIMEOUT_EN
        else if (timeout) begin
          state_d = ST_HALTED;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end
`endif
      end
      ST_RUNNING: begin
        cpu_run_d = 1'b1;
        if (halt_req) begin
          state_d    = ST_STOPPING;
          halt_req_d = 1'b1;
          busy_d     = 1'b1;
        end else if (run_req) begin
          done_d = 1'b1;
        end
      end
      ST_STOPPING: begin
        if (cpu_halted) begin
          state_d = ST_WAIT_HALT;
        end
`ifdef SPI_OWN_TIMEOUT_EN
        else if (timeout) begin
          state_d    = ST_RUNNING;
          halt_req_d = 1'b0;
          busy_d     = 1'b0;
          err_d      = 1'b1;
        end
`endif
      end
      ST_WAIT_HALT: begin
        // cpu_halted is deliberately not re-checked here.
        if (bus_idle) begin
          state_d    = ST_HALTED;
          cpu_run_d  = 1'b0;
          halt_req_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
`ifdef SPI_OWN_TIMEOUT_EN
        else if (timeout) begin
          state_d    = ST_RUNNING;
          halt_req_d = 1'b0;
          busy_d     = 1'b0;
          err_d      = 1'b1;
        end
`endif
      end
      default: begin
        state_d    = ST_HALTED;
        cpu_run_d  = 1'b0;
        halt_req_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HALTED;
      cpu_run_q  <= 1'b0;
      halt_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_run_q  <= cpu_run_d;
      halt_req_q <= halt_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cpu_run      = cpu_run_q;
  assign cpu_halt_req = halt_req_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_spi_owner_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_owner_ctrl
//
// Directed self-checking bench for spi_owner_ctrl with IDLE_CYCLES=4 and
// TIMEOUT_CYCLES=32. Inputs are driven and outputs sampled 1 time unit after
// each rising clk edge. Expected latencies are derived by hand:
//   nss release -> switch : 2 sync flops + IDLE_CYCLES + 1 = 7 edges
//   last sck toggle -> switch : 2 sync + 1 edge-detect + IDLE_CYCLES + 1 = 8
// -----------------------------------------------------------------------------
module tb_spi_owner_ctrl;

  localparam int IDLE    = 4;
  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic rst;
  logic spi_sck;
  logic spi_nss_in;
  logic run_req;
  logic halt_req;
  logic cpu_halted;
  logic cpu_run;
  logic cpu_halt_req;
  logic busy;
  logic done;
  logic err;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  spi_owner_ctrl #(
    .IDLE_CYCLES   (IDLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_nss_in  (spi_nss_in),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .cpu_halted  (cpu_halted),
    .cpu_run     (cpu_run),
    .cpu_halt_req(cpu_halt_req),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int cycles = 1);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run_req = 1'b1;
    step();
    run_req = 1'b0;
  endtask

  task automatic pulse_halt();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
  endtask

  // Counts edges until cpu_run reaches target; gives up at 40 edges, which
  // then shows up as a wrong latency in the caller's check.
  task automatic edges_until_run(input logic target, output int edges);
    edges = 0;
    while (cpu_run !== target && edges < 40) begin
      step();
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    spi_sck    = 1'b0;
    spi_nss_in = 1'b1;
    run_req    = 1'b0;
    halt_req   = 1'b0;
    cpu_halted = 1'b0;

    // Reset state
    step(3);
    check("rst_cpu_run",  cpu_run,      0);
    check("rst_halt_req", cpu_halt_req, 0);
    check("rst_busy",     busy,         0);
    check("rst_done",     done,         0);
    check("rst_err",      err,          0);
    rst = 1'b0;
    step(10);

    // Run request with the bus already idle: switch on the next edge
    pulse_run();
    check("run_busy",     busy,    1);
    check("run_not_yet",  cpu_run, 0);
    step();
    check("run_cpu_run",  cpu_run, 1);
    check("run_done",     done,    1);
    check("run_busy_end", busy,    0);
    step();
    check("run_done_end", done,    0);

    // run_req while already running is a no-op acknowledge
    pulse_run();
    check("noop_run_done", done,    1);
    check("noop_run_busy", busy,    0);
    check("noop_run_own",  cpu_run, 1);

    // Halt: request to CPU, wait for cpu_halted, then hand over
    pulse_halt();
    check("stop_halt_req", cpu_halt_req, 1);
    check("stop_busy",     busy,         1);
    check("stop_own",      cpu_run,      1);
    step(10);
    check("stop_hold_own", cpu_run,      1);
    check("stop_hold_req", cpu_halt_req, 1);
    cpu_halted = 1'b1;
    step();
    check("whalt_own",     cpu_run,      1);
    step();
    check("halted_own",    cpu_run,      0);
    check("halted_req",    cpu_halt_req, 0);
    check("halted_done",   done,         1);
    check("halted_busy",   busy,         0);
    cpu_halted = 1'b0;

    // Simultaneous run_req and halt_req while halted: halt wins (no-op done)
    run_req  = 1'b1;
    halt_req = 1'b1;
    step();
    run_req  = 1'b0;
    halt_req = 1'b0;
    check("both_done", done,    1);
    check("both_busy", busy,    0);
    step();
    check("both_drop", busy,    0);
    check("both_own",  cpu_run, 0);

    // Run request during an active frame waits for nss release
    spi_nss_in = 1'b0;
    step(3);
    pulse_run();
    check("nss_busy",      busy,    1);
    check("nss_own",       cpu_run, 0);
    step(5);
    check("nss_hold",      cpu_run, 0);
    pulse_halt();
    check("ignored_done",  done,         0);
    check("ignored_busy",  busy,         1);
    check("ignored_req",   cpu_halt_req, 0);
    spi_nss_in = 1'b1;
    edges_until_run(1'b1, n);
    check("nss_release_lat", n, 2 + IDLE + 1);
    check("nss_release_done", done, 1);

    // Halt while sck toggles every 3 cycles: the idle window is never reached
    cpu_halted = 1'b1;
    repeat (2) begin
      spi_sck = ~spi_sck;
      step(3);
    end
    halt_req = 1'b1;
    spi_sck  = ~spi_sck;
    step();
    halt_req = 1'b0;
    check("sck_halt_req", cpu_halt_req, 1);
    repeat (4) begin
      step(2);
      spi_sck = ~spi_sck;
      step();
      check("sck_toggle_hold", cpu_run, 1);
    end
    step(2);
    spi_sck = ~spi_sck;
    edges_until_run(1'b0, n);
    check("sck_quiet_lat",  n, 3 + IDLE + 1);
    check("sck_quiet_req",  cpu_halt_req, 0);
    check("sck_quiet_done", done, 1);
    cpu_halted = 1'b0;

    // Reset in the middle of a transition: back to HALTED, no pulses
    spi_nss_in = 1'b0;
    step(2);
    pulse_run();
    check("mid_rst_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", busy,    0);
    check("mid_rst_done", done,    0);
    check("mid_rst_err",  err,     0);
    check("mid_rst_own",  cpu_run, 0);

    // Run request that can never complete (nss held low)
    step(3);
    pulse_run();
    check("to_entry_busy", busy, 1);
`ifdef SPI_OWN_TIMEOUT_EN
    step(TIMEOUT - 1);
    check("to_pre_busy",  busy, 1);
    check("to_pre_err",   err,  0);
    step();
    check("to_err",       err,     1);
    check("to_busy",      busy,    0);
    check("to_own",       cpu_run, 0);
    check("to_no_done",   done,    0);
    step();
    check("to_err_end",   err,     0);

    // Stop request that the CPU never honours: abort back to RUNNING
    spi_nss_in = 1'b1;
    step(10);
    pulse_run();
    step();
    check("to2_running",  cpu_run, 1);
    pulse_halt();
    step(TIMEOUT - 1);
    check("to2_pre_req",  cpu_halt_req, 1);
    step();
    check("to2_err",      err,          1);
    check("to2_own",      cpu_run,      1);
    check("to2_req",      cpu_halt_req, 0);
    check("to2_busy",     busy,         0);
`else
    step(TIMEOUT + 8);
    check("wait_busy",    busy,    1);
    check("wait_err",     err,     0);
    check("wait_own",     cpu_run, 0);
    spi_nss_in = 1'b1;
    edges_until_run(1'b1, n);
    check("wait_release_lat", n, 2 + IDLE + 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
